fb_pixel_writer: RTL and testbench

//  Writer side of the panel framebuffer: accepts (x, y, rgb) pixel commands and stores

---
 rtl/fb_pixel_writer_pkg.sv | 22 ++
 rtl/fb_pixel_writer_addr_map.sv | 32 +++
 rtl/fb_pixel_writer.sv | 172 +++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// Shared framebuffer writer definitions: geometry defaults and FSM states.
// FB_CLEAR_EN adds the clear-screen state.
package fb_pixel_writer_pkg;

  localparam int FB_WIDTH  = 96;
  localparam int FB_HEIGHT = 48;
  localparam int FB_BPP    = 12;
  localparam int FB_AW     = 12;
  localparam int XW        = 7;
  localparam int YW        = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR
`ifdef FB_CLEAR_EN
    , ST_CLR
`endif
  } state_t;

endpackage

// File: rtl/fb_pixel_writer_addr_map.sv
// Pixel coordinate to memory word mapping.
// Top rows share a word with the matching bottom row.
module fb_pixel_writer_addr_map
  import fb_pixel_writer_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int AW     = FB_AW
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          half,
  output logic          in_range
);

  localparam logic [YW-1:0] HALF_Y = YW'(HEIGHT / 2);
  localparam logic [YW-1:0] H_Y    = YW'(HEIGHT);
  localparam logic [XW-1:0] W_X    = XW'(WIDTH);
  localparam logic [AW-1:0] W_A    = AW'(WIDTH);

  logic [YW-1:0] row;

  // Split y into half select and row within half, then linearise.
  always_comb begin
    half     = (y >= HALF_Y);
    row      = half ? (y - HALF_Y) : y;
    addr     = AW'(row) * W_A + AW'(x);
    in_range = (x < W_X) && (y < H_Y);
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: read-modify-write of packed pixel pairs.
// Optional clear-screen engine under FB_CLEAR_EN.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int BPP    = FB_BPP,
  parameter int AW     = FB_AW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_px_valid,
  output logic             o_px_ready,
  input  logic [XW-1:0]    i_px_x,
  input  logic [YW-1:0]    i_px_y,
  input  logic [BPP-1:0]   i_px_rgb,
  output logic             o_px_err,
  output logic             o_busy,
  output logic [AW-1:0]    o_addr,
  output logic [2*BPP-1:0] o_data,
  output logic             o_wr_en,
  output logic             o_rd_en,
  input  logic [2*BPP-1:0] i_rd_data,
  input  logic             i_clr_req,
  input  logic [BPP-1:0]   i_clr_rgb,
  output logic             o_clr_done
);

  localparam int DW = 2 * BPP;

  state_t          state, nxt;
  logic [AW-1:0]   map_addr;
  logic            map_half;
  logic            map_ok;
  logic [AW-1:0]   px_addr;
  logic            px_half;
  logic [BPP-1:0]  px_rgb;
  logic [DW-1:0]   merged;
  logic            err_q;
  logic            clr_go;

`ifdef FB_CLEAR_EN
  localparam int FB_DEPTH = WIDTH * HEIGHT / 2;
  localparam logic [AW-1:0] LAST_A = AW'(FB_DEPTH - 1);
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_word;
  logic          clr_done_q;
  assign clr_go     = i_clr_req;
  assign o_clr_done = clr_done_q;
`else
  logic unused_clr;
  assign unused_clr = ^{i_clr_req, i_clr_rgb};
  assign clr_go     = 1'b0;
  assign o_clr_done = 1'b0;
`endif

  fb_pixel_writer_addr_map #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .AW    (AW)
  ) u_map (
    .x       (i_px_x),
    .y       (i_px_y),
    .addr    (map_addr),
    .half    (map_half),
    .in_range(map_ok)
  );

  assign o_px_ready = (state == ST_IDLE) & ~clr_go;
  assign o_busy     = (state != ST_IDLE);
  assign o_px_err   = err_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state: one RMW pass per accepted in-range command.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_go) begin
`ifdef FB_CLEAR_EN
          nxt = ST_CLR;
`endif
        end else if (i_px_valid && map_ok) begin
          nxt = ST_RD;
        end
      end
      ST_RD:   nxt = ST_WAIT;
      ST_WAIT: nxt = ST_WR;
      ST_WR:   nxt = ST_IDLE;
`ifdef FB_CLEAR_EN
      ST_CLR:  if (clr_cnt == LAST_A) nxt = ST_IDLE;
`endif
      default: nxt = ST_IDLE;
    endcase
  end

  // Command latch, merge of the old word, error and clear bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      px_addr <= '0;
      px_half <= 1'b0;
      px_rgb  <= '0;
      merged  <= '0;
      err_q   <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt    <= '0;
      clr_word   <= '0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_done_q <= 1'b0;
      if (state == ST_IDLE && clr_go) begin
        clr_cnt  <= '0;
        clr_word <= {i_clr_rgb, i_clr_rgb};
      end
      if (state == ST_CLR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_A) clr_done_q <= 1'b1;
      end
`endif
      if (state == ST_IDLE && !clr_go && i_px_valid) begin
        if (map_ok) begin
          px_addr <= map_addr;
          px_half <= map_half;
          px_rgb  <= i_px_rgb;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        merged <= px_half ? {i_rd_data[DW-1:BPP], px_rgb}
                          : {px_rgb, i_rd_data[BPP-1:0]};
      end
    end
  end

  // Port A drive, decoded from state only.
  always_comb begin
    o_addr  = '0;
    o_data  = '0;
    o_rd_en = 1'b0;
    o_wr_en = 1'b0;
    unique case (state)
      ST_RD: begin
        o_addr  = px_addr;
        o_rd_en = 1'b1;
      end
      ST_WR: begin
        o_addr  = px_addr;
        o_data  = merged;
        o_wr_en = 1'b1;
      end
`ifdef FB_CLEAR_EN
      ST_CLR: begin
        o_addr  = clr_cnt;
        o_data  = clr_word;
        o_wr_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a behavioural port A memory.
// Clear tests are built only with FB_CLEAR_EN.
`timescale 1ns/1ps
module tb_fb_pixel_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_px_valid = 1'b0;
  logic        o_px_ready;
  logic [6:0]  i_px_x = '0;
  logic [5:0]  i_px_y = '0;
  logic [11:0] i_px_rgb = '0;
  logic        o_px_err;
  logic        o_busy;
  logic [11:0] o_addr;
  logic [23:0] o_data;
  logic        o_wr_en;
  logic        o_rd_en;
  logic [23:0] i_rd_data = '0;
  logic        i_clr_req = 1'b0;
  logic [11:0] i_clr_rgb = '0;
  logic        o_clr_done;

  logic [23:0] mem [0:4095];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int overlap = 0;
  int done_cnt = 0;

  fb_pixel_writer dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_px_valid(i_px_valid),
    .o_px_ready(o_px_ready),
    .i_px_x    (i_px_x),
    .i_px_y    (i_px_y),
    .i_px_rgb  (i_px_rgb),
    .o_px_err  (o_px_err),
    .o_busy    (o_busy),
    .o_addr    (o_addr),
    .o_data    (o_data),
    .o_wr_en   (o_wr_en),
    .o_rd_en   (o_rd_en),
    .i_rd_data (i_rd_data),
    .i_clr_req (i_clr_req),
    .i_clr_rgb (i_clr_rgb),
    .o_clr_done(o_clr_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rd_en) begin
      i_rd_data = mem[o_addr];
      rd_cnt++;
    end
    if (o_wr_en) begin
      mem[o_addr] = o_data;
      wr_cnt++;
    end
    if (o_rd_en && o_wr_en) overlap++;
    if (o_clr_done) done_cnt++;
  end

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [6:0] x, input logic [5:0] y,
                     input logic [11:0] rgb);
    i_px_valid = 1'b1;
    i_px_x     = x;
    i_px_y     = y;
    i_px_rgb   = rgb;
  endtask

  int w0;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[293] = 24'h000ABC;

    // reset held four cycles
    i_rst = 1'b0;
    repeat (4) step();
    chk("rst_outs", {o_addr, o_wr_en, o_rd_en, o_px_err, o_busy}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_clr_done, 0);
    i_rst = 1'b1;
    step();
    chk("rst_ready", o_px_ready, 1);

    // bottom-less pixel into top half of word 293
    cmd(7'd5, 6'd3, 12'hF00);
    chk("p1_ready", o_px_ready, 1);
    step();
    i_px_valid = 1'b0;
    chk("p1_rd", {o_rd_en, o_wr_en, o_busy}, 3'b101);
    chk("p1_rd_addr", o_addr, 293);
    step();
    chk("p1_wait", {o_rd_en, o_wr_en}, 0);
    step();
    chk("p1_wr", {o_rd_en, o_wr_en}, 2'b01);
    chk("p1_wr_addr", o_addr, 293);
    chk("p1_wr_data", o_data, 24'hF00ABC);
    step();
    chk("p1_idle", {o_px_ready, o_busy}, 2'b10);

    // bottom half, same word, top preserved
    cmd(7'd5, 6'd27, 12'h0F0);
    step();
    i_px_valid = 1'b0;
    chk("p2_rd_addr", o_addr, 293);
    step();
    step();
    chk("p2_wr_data", o_data, 24'hF000F0);
    step();
    chk("p2_mem", mem[293], 24'hF000F0);

    // out-of-range commands
    w0 = wr_cnt + rd_cnt;
    cmd(7'd96, 6'd0, 12'hFFF);
    step();
    i_px_valid = 1'b0;
    chk("err_x", {o_px_err, o_rd_en, o_px_ready, o_busy}, 4'b1010);
    step();
    chk("err_x_pulse", o_px_err, 0);
    cmd(7'd0, 6'd48, 12'hFFF);
    step();
    i_px_valid = 1'b0;
    chk("err_y", {o_px_err, o_rd_en, o_px_ready, o_busy}, 4'b1010);
    step();
    chk("err_y_pulse", o_px_err, 0);
    chk("err_no_access", wr_cnt + rd_cnt, w0);

    // valid held high, four commands back to back
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: cmd(7'd0, 6'd0, 12'h111);
        1: cmd(7'd1, 6'd0, 12'h222);
        2: cmd(7'd0, 6'd24, 12'h333);
        default: cmd(7'd95, 6'd47, 12'h444);
      endcase
      chk("b2b_ready", o_px_ready, 1);
      step();
      if (i == 3) i_px_valid = 1'b0;
      chk("b2b_busy", {o_px_ready, o_rd_en}, 2'b01);
      step();
      chk("b2b_wait_rdy", o_px_ready, 0);
      step();
      chk("b2b_wr_rdy", {o_px_ready, o_wr_en}, 2'b01);
      step();
    end
    chk("b2b_writes", wr_cnt - w0, 4);
    chk("b2b_overlap", overlap, 0);
    chk("b2b_mem0", mem[0], 24'h111333);
    chk("b2b_mem1", mem[1], 24'h222000);
    chk("b2b_mem_last", mem[2303], 24'h000444);

`ifdef FB_CLEAR_EN
    // clear wins over a pending pixel
    w0 = wr_cnt;
    i_clr_req = 1'b1;
    i_clr_rgb = 12'h123;
    cmd(7'd2, 6'd0, 12'hABC);
    chk("clr_ready", o_px_ready, 0);
    step();
    i_clr_req = 1'b0;
    i_clr_rgb = 12'h000;
    chk("clr_first", {o_wr_en, o_busy}, 2'b11);
    chk("clr_first_addr", o_addr, 0);
    chk("clr_first_data", o_data, 24'h123123);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
        step();
        if (o_clr_done) seen = 1'b1;
      end
      chk("clr_done_seen", seen, 1);
    end
    chk("clr_writes", wr_cnt - w0, 2304);
    chk("clr_mem_lo", mem[0], 24'h123123);
    chk("clr_mem_mid", mem[1000], 24'h123123);
    chk("clr_mem_hi", mem[2303], 24'h123123);
    chk("clr_not_past", mem[2304], 24'h000000);
    chk("clr_ready_after", o_px_ready, 1);
    step();
    i_px_valid = 1'b0;
    chk("clr_done_once", done_cnt, 1);
    repeat (4) step();
    chk("clr_px_after", mem[2], 24'hABC123);

    // reset aborts a clear part-way
    i_clr_req = 1'b1;
    i_clr_rgb = 12'h456;
    step();
    i_clr_req = 1'b0;
    w0 = wr_cnt;
    for (int c = 0; c < 200 && (wr_cnt - w0) < 99; c++) step();
    i_rst = 1'b0;
    step();
    chk("clr_rst_idle", {o_wr_en, o_busy, o_clr_done}, 0);
    chk("clr_rst_count", wr_cnt - w0, 100);
    i_rst = 1'b1;
    w0 = wr_cnt;
    repeat (5) step();
    chk("clr_rst_stopped", wr_cnt, w0);
    chk("clr_rst_no_done", done_cnt, 1);
    chk("clr_rst_partial", mem[150], 24'h123123);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
